// File: rtl/fetch_control_pkg.sv
// fetch_control_pkg
//   Shared definitions for the instruction-fetch sequencer: default widths,
//   the halt opcode and the 3-bit FSM state encodings. The execute stage
//   imports the same package so both sides agree on the opcode field.
//   No ports (package only).
package fetch_control_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int INSTR_W_DEF = 16;
    localparam int OP_W_DEF    = 4;

    localparam logic [OP_W_DEF-1:0] HALT_OP_DEF = 4'hF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;

endpackage

// File: rtl/fetch_control_instr_reg.sv
// instr_reg
//   Instruction register plus its valid flag. The fetch FSM strobes `load`
//   when the ROM word is on `d`, and `accept` when the execute stage takes
//   the word. The register contents are kept after acceptance; only the
//   valid flag drops.
// Ports
//   clk       in   clock, all updates on posedge
//   rst       in   asynchronous active-high reset
//   load      in   capture d, raise valid
//   accept    in   execute stage took the word, drop valid
//   d         in   [INSTR_W-1:0] ROM read data
//   ir        out  [INSTR_W-1:0] instruction register
//   ir_valid  out  ir holds a word not yet accepted
module instr_reg
    import fetch_control_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               accept,
    input  logic [INSTR_W-1:0] d,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid
);

    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;

    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (load) begin
            ir_d       = d;
            ir_valid_d = 1'b1;
        end else if (accept) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: rtl/fetch_control.sv
// fetch_control
//   Instruction-fetch sequencer between the program counter and a
//   synchronous instruction ROM. Clears the PC on Start, addresses the ROM
//   with the PC, latches the returned word into the IR and hands it to the
//   execute stage over a valid/ready handshake; one word every 3 cycles
//   when the execute stage never stalls.
//   Optional feature macro: FETCH_HALT_DETECT_EN -- when defined, an accepted
//   word whose opcode equals HALT_OP stops fetching (HALT state) until the
//   next Start. When undefined, HALT is unreachable and Halted is 0.
// Ports
//   Clock    in   clock
//   Reset    in   asynchronous active-high reset
//   Start    in   (re)start from address 0; honoured in IDLE and HALT only
//   PC       in   [ADDR_W-1:0]  current program counter
//   Up       out  PC increment request (one cycle, in LOAD)
//   Clear    out  PC clear request (one cycle, in CLR)
//   IAddr    out  [ADDR_W-1:0]  ROM address, combinational copy of PC
//   IData    in   [INSTR_W-1:0] ROM data, valid one cycle after IAddr
//   IR       out  [INSTR_W-1:0] instruction register
//   IRValid  out  IR holds a word not yet accepted
//   IRReady  in   execute stage accepts when IRValid & IRReady at posedge
//   Halted   out  high while in HALT
//
// state | meaning
// IDLE  | waiting for Start after reset
// CLR   | Clear=1, PC goes to 0 at this edge
// FETCH | ROM samples IAddr=PC at this edge
// LOAD  | IR<=IData, IRValid<=1, Up=1 (PC+1 at this edge)
// HOLD  | IR presented until accepted
// HALT  | halt opcode accepted, waiting for Start
module fetch_control
    import fetch_control_pkg::*;
#(
    parameter int               ADDR_W  = ADDR_W_DEF,
    parameter int               INSTR_W = INSTR_W_DEF,
    parameter int               OP_W    = OP_W_DEF,
    parameter logic [OP_W-1:0]  HALT_OP = HALT_OP_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [ADDR_W-1:0]  PC,
    output logic               Up,
    output logic               Clear,
    output logic [ADDR_W-1:0]  IAddr,
    input  logic [INSTR_W-1:0] IData,
    output logic [INSTR_W-1:0] IR,
    output logic               IRValid,
    input  logic               IRReady,
    output logic               Halted
);

`ifdef FETCH_HALT_DETECT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    logic [2:0] state_q, state_d;
    logic       load;
    logic       accept;
    logic       go_halt;

    assign load    = (state_q == ST_LOAD);
    assign accept  = (state_q == ST_HOLD) && IRValid && IRReady;
    // Opcode is taken from the word being accepted, which is the IR itself.
    assign go_halt = HALT_EN && (IR[INSTR_W-1 -: OP_W] == HALT_OP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_CLR;
            ST_CLR:   state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_HOLD;
            ST_HOLD:  if (accept) state_d = go_halt ? ST_HALT : ST_FETCH;
            ST_HALT:  if (Start) state_d = ST_CLR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    instr_reg #(
        .INSTR_W (INSTR_W)
    ) u_instr_reg (
        .clk      (Clock),
        .rst      (Reset),
        .load     (load),
        .accept   (accept),
        .d        (IData),
        .ir       (IR),
        .ir_valid (IRValid)
    );

    // Moore decodes: Up and Clear come from distinct states, never together.
    assign Up     = (state_q == ST_LOAD);
    assign Clear  = (state_q == ST_CLR);
    assign Halted = HALT_EN && (state_q == ST_HALT);
    assign IAddr  = PC;

endmodule

// File: tb/tb_fetch_control.sv
module tb_fetch_control;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [4:0]  PC;
    logic        Up;
    logic        Clear;
    logic [4:0]  IAddr;
    logic [15:0] IData;
    logic [15:0] IR;
    logic        IRValid;
    logic        IRReady;
    logic        Halted;

    fetch_control dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .PC      (PC),
        .Up      (Up),
        .Clear   (Clear),
        .IAddr   (IAddr),
        .IData   (IData),
        .IR      (IR),
        .IRValid (IRValid),
        .IRReady (IRReady),
        .Halted  (Halted)
    );

    always #5 Clock = ~Clock;

    // Environment: PC block and synchronous ROM. clear_val lets a test
    // start the PC somewhere other than 0 to exercise wrap-around.
    logic [15:0] rom [32];
    logic [4:0]  clear_val;

    always @(posedge Clock or posedge Reset) begin
        if (Reset)      PC <= 5'd0;
        else if (Clear) PC <= clear_val;
        else if (Up)    PC <= PC + 5'd1;
    end

    always @(posedge Clock) IData <= rom[IAddr];

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          clear_cnt = 0;
    logic [15:0] exp_q [$];
    bit          hold_pending = 0;
    logic [15:0] held_ir;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: every accepted word must be the next expected one.
    always @(negedge Clock) begin
        if (Clear) begin
            clear_cnt++;
            check("up_with_clear", {31'd0, Up}, 32'd0);
        end
        if (Reset) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {31'd0, IRValid}, 32'd1);
                check("hold_ir", {16'd0, IR}, {16'd0, held_ir});
            end
            hold_pending = IRValid && !IRReady;
            held_ir      = IR;
            if (IRValid && IRReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", IR);
                end else begin
                    check("ir_word", {16'd0, IR}, {16'd0, exp_q.pop_front()});
                end
                acc_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 32; i++) begin
            rom[i] = 16'($urandom);
            rom[i][15:12] = 4'($urandom_range(0, 14));
        end
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        Start   = 1'b0;
        IRReady = 1'b0;
        exp_q.delete();
        tick(2);
        Reset = 1'b0;
        tick(1);
    endtask

    // Reference model: a run from base fetches base, base+1, ... modulo 32.
    task automatic push_run(input int base, input int n);
        logic [4:0] a;
        for (int i = 0; i < n; i++) begin
            a = 5'(base + i);
            exp_q.push_back(rom[a]);
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
    endtask

    task automatic wait_acc(input int target, input int bound, input string name);
        int n;
        n = 0;
        while (acc_cnt < target && n < bound) begin
            tick(1);
            n++;
        end
        checks++;
        if (acc_cnt < target) begin
            errors++;
            $display("FAIL %s: got %0d accepts expected %0d", name, acc_cnt, target);
        end
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (!IRValid && n < bound) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int c0;
        int a0;
        logic [15:0] basic_words [3];

        Reset     = 1'b1;
        Start     = 1'b1;
        IRReady   = 1'b0;
        clear_val = 5'd0;
        fill_rom();

        // Reset state, with Start held during reset.
        tick(2);
        check("rst_irvalid", {31'd0, IRValid}, 32'd0);
        check("rst_ir", {16'd0, IR}, 32'd0);
        check("rst_up", {31'd0, Up}, 32'd0);
        check("rst_clear", {31'd0, Clear}, 32'd0);
        check("rst_halted", {31'd0, Halted}, 32'd0);
        Reset = 1'b0;
        Start = 1'b0;
        tick(3);
        check("start_in_reset_ignored", {31'd0, Clear | IRValid}, 32'd0);

        // Basic run with known words and IRReady tied high.
        basic_words[0] = 16'h1234;
        basic_words[1] = 16'h2345;
        basic_words[2] = 16'h3456;
        for (int i = 0; i < 3; i++) rom[i] = basic_words[i];
        IRReady = 1'b1;
        c0 = clear_cnt;
        a0 = acc_cnt;
        push_run(0, 6);
        pulse_start();
        wait_valid(10, n);
        check("first_latency", n, 3);
        check("first_ir", {16'd0, IR}, 32'h1234);
        check("pc_after_load0", {27'd0, PC}, 32'd1);
        for (int k = 1; k < 3; k++) begin
            n = 0;
            while (IRValid && n < 20) begin tick(1); n++; end
            while (!IRValid && n < 20) begin tick(1); n++; end
            check("valid_period", n, 3);
            check("basic_ir", {16'd0, IR}, {16'd0, basic_words[k]});
            check("pc_after_load", {27'd0, PC}, k + 1);
        end
        wait_acc(a0 + 6, 40, "basic_accepts");
        check("basic_clear_pulses", clear_cnt - c0, 1);

        // Stall on the first word, then random IRReady with stray Start pulses.
        do_reset();
        fill_rom();
        c0 = clear_cnt;
        a0 = acc_cnt;
        push_run(0, 40);
        pulse_start();
        wait_valid(10, n);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_valid", {31'd0, IRValid}, 32'd1);
            check("stall_up", {31'd0, Up}, 32'd0);
            check("stall_pc", {27'd0, PC}, 32'd1);
            check("stall_ir", {16'd0, IR}, {16'd0, rom[0]});
        end
        IRReady = 1'b1;
        tick(1);
        check("accept_next_edge", {31'd0, IRValid}, 32'd0);
        n = 0;
        while (acc_cnt < a0 + 30 && n < 600) begin
            IRReady = 1'($urandom_range(0, 1));
            Start   = ($urandom_range(0, 7) == 0);
            tick(1);
            n++;
        end
        Start = 1'b0;
        wait_acc(a0 + 30, 10, "random_accepts");
        check("random_clear_pulses", clear_cnt - c0, 1);

        // PC wrap: start at 30, words at 30, 31, 0, 1 without another Clear.
        do_reset();
        fill_rom();
        clear_val = 5'd30;
        IRReady = 1'b1;
        c0 = clear_cnt;
        a0 = acc_cnt;
        push_run(30, 4);
        pulse_start();
        wait_acc(a0 + 4, 40, "wrap_accepts");
        check("wrap_clear_pulses", clear_cnt - c0, 1);
        clear_val = 5'd0;

        // Halt opcode at address 2.
        do_reset();
        fill_rom();
        rom[2] = 16'hF000;
        IRReady = 1'b1;
        c0 = clear_cnt;
        a0 = acc_cnt;
`ifdef FETCH_HALT_DETECT_EN
        push_run(0, 3);
        pulse_start();
        wait_acc(a0 + 3, 40, "halt_accepts");
        tick(2);
        check("halted", {31'd0, Halted}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("halt_up", {31'd0, Up}, 32'd0);
            check("halt_valid", {31'd0, IRValid}, 32'd0);
        end
        check("halt_ir_persists", {16'd0, IR}, 32'hF000);
        check("halt_acc_count", acc_cnt - a0, 3);
        push_run(0, 2);
        pulse_start();
        check("restart_unhalted", {31'd0, Halted}, 32'd0);
        check("restart_clear", {31'd0, Clear}, 32'd1);
        wait_acc(a0 + 5, 40, "restart_accepts");
        check("halt_clear_pulses", clear_cnt - c0, 2);
`else
        push_run(0, 6);
        pulse_start();
        wait_acc(a0 + 6, 60, "nohalt_accepts");
        check("never_halted", {31'd0, Halted}, 32'd0);
        check("nohalt_clear_pulses", clear_cnt - c0, 1);
`endif

        // Reset while holding a valid word; Start held through reset.
        do_reset();
        fill_rom();
        pulse_start();
        wait_valid(10, n);
        check("pre_reset_valid", {31'd0, IRValid}, 32'd1);
        #3;
        Reset = 1'b1;
        Start = 1'b1;
        #1;
        check("midreset_valid", {31'd0, IRValid}, 32'd0);
        check("midreset_ir", {16'd0, IR}, 32'd0);
        check("midreset_up", {31'd0, Up | Clear}, 32'd0);
        exp_q.delete();
        c0 = clear_cnt;
        tick(3);
        Reset = 1'b0;
        Start = 1'b0;
        tick(5);
        check("post_reset_no_clear", clear_cnt - c0, 0);
        check("post_reset_idle", {31'd0, IRValid}, 32'd0);
        IRReady = 1'b1;
        a0 = acc_cnt;
        push_run(0, 2);
        pulse_start();
        wait_acc(a0 + 2, 40, "post_reset_accepts");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
